spi_slave_stream: RTL and testbench
===================================

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the SPI word width in bits (legal range 4..32).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth on sclk, mosi and ss_n (minimum 2).
REQ-003 The block SHALL have parameter TX_IDLE, default all-zeros, meaning the word shifted out when no TX data is available.
REQ-004 The block SHALL have parameter LOOPBACK_INC, default 0; when 1, each TX word SHALL be the last received word + 1.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; the block SHALL use no other clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have SPI pins: sclk (input, 1), mosi (input, 1), ss_n (input, 1, active-low select) and miso (output, 1).
REQ-008 The block SHALL have an RX stream: rx_data (output, DATA_W), rx_valid (output, 1) and rx_ready (input, 1).
REQ-009 The block SHALL have a TX stream: tx_data (input, DATA_W), tx_valid (input, 1) and tx_ready (output, 1).
REQ-010 The block SHALL have status outputs, 1 bit each: busy, overrun (sticky) and underrun (sticky).

Function
REQ-011 SPI mode SHALL be 0 (CPOL=0, CPHA=0), MSB first; clk frequency SHALL be at least 8x the sclk frequency.
REQ-012 sclk, mosi and ss_n SHALL pass through SYNC_STAGES flip-flops; all edge detection SHALL use the synchronized values only.
REQ-013 FSM states: IDLE (ss_n high), LOAD (fetch TX word, one clk), SHIFT (transfer bits).
REQ-014 IDLE->LOAD SHALL occur on the cycle a synchronized ss_n falling edge is detected; LOAD->SHIFT SHALL be unconditional after one cycle.
REQ-015 In SHIFT, each synchronized sclk rising edge SHALL shift the synchronized mosi into the LSB of the RX shift register and increment a bit counter.
REQ-016 In SHIFT, each synchronized sclk falling edge SHALL advance miso to the next TX bit.
REQ-017 When the DATA_W-th rising edge occurs, the word SHALL be complete, the bit counter SHALL clear, and the next falling edge SHALL cause SHIFT->LOAD.
REQ-018 tx_ready SHALL be 1 only during LOAD, and only when LOOPBACK_INC=0.
REQ-019 If tx_valid=1 in LOAD, tx_data SHALL be captured; otherwise TX_IDLE SHALL be loaded and underrun SHALL set.
REQ-020 miso SHALL present the MSB of the loaded word from the cycle after LOAD; miso SHALL be 0 whenever ss_n (synchronized) is high.
REQ-021 With LOOPBACK_INC=1, LOAD SHALL use (last completed RX word + 1) mod 2^DATA_W, starting from 0 after reset, and underrun SHALL never set.
REQ-022 rx_data/rx_valid SHALL update on the clk after the completing rising edge; rx_valid SHALL hold until the cycle rx_valid&rx_ready=1, then clear.
REQ-023 If a word completes while rx_valid=1 and rx_ready=0, the new word SHALL be dropped, rx_data SHALL be unchanged, and overrun SHALL set.
REQ-024 A completion in the same cycle as an accepting handshake SHALL load the new word with rx_valid remaining 1 and no overrun.
REQ-025 A synchronized ss_n rising edge in any state SHALL discard the partial word (no rx_valid), clear the bit counter, and go to IDLE; a TX word already taken SHALL not be re-requested.
REQ-026 sclk edges while in IDLE or LOAD SHALL be ignored.
REQ-027 busy SHALL be 1 in LOAD and SHIFT, and 0 in IDLE.
REQ-028 overrun and underrun SHALL clear only on rst.

Reset
REQ-029 While rst=1: state=IDLE, bit counter=0, shift registers=0, synchronizers loaded with ss_n=1 and sclk=0, rx_data=0, rx_valid=0, tx_ready=0, miso=0, busy=0, overrun=0, underrun=0, loopback word=0.
REQ-030 rst asserted mid-frame SHALL abort the frame; after rst releases, the block SHALL wait for a fresh ss_n falling edge before any transfer.

Verification
REQ-031 Basic RX: DATA_W=16, master sends 0xA55A with rx_ready=1 -> one rx_valid pulse with rx_data=0xA55A, overrun=0.
REQ-032 TX handshake: tx_valid=1 with tx_data=0x1234 before ss_n falls -> tx_ready pulses once and the master reads 0x1234 on miso; a second back-to-back word with tx_valid=0 -> master reads TX_IDLE and underrun=1.
REQ-033 Overrun: rx_ready=0, two words 0x0001 then 0x0002 -> rx_data stays 0x0001 and overrun=1; after rx_ready=1 exactly one handshake occurs.
REQ-034 Loopback: LOOPBACK_INC=1, master sends 0x00FF then 0x1000 in one frame -> the master reads 0x0000 then 0x0100; tx_ready is never 1.
REQ-035 Abort: ss_n raised after 7 bits of a 16-bit word -> no rx_valid, busy=0 within SYNC_STAGES+2 clk, and the next full word 0xBEEF is received correctly.
REQ-036 Reset mid-frame: rst pulsed after 9 bits -> all outputs match REQ-029 and the following frame transfers 0xC3C3 correctly.

Source files
------------

// File: rtl/spi_slave_stream.sv
// SPI mode-0 slave with valid/ready RX and TX word streams, run entirely on the
// system clock: the SPI pins are synchronized and their edges detected here.
module spi_slave_stream #(
    parameter int unsigned        DATA_W       = 16,
    parameter int unsigned        SYNC_STAGES  = 2,
    parameter logic [DATA_W-1:0]  TX_IDLE      = '0,
    parameter bit                 LOOPBACK_INC = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss_n,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              busy,
    output logic              overrun,
    output logic              underrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] prime_q, prime_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   armed_q, armed_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   word_done_q, word_done_d;
    logic [DATA_W-2:0]      rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0]      tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   tx_ready_q, tx_ready_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;
    logic                   underrun_q, underrun_d;
    logic [DATA_W-1:0]      lb_word_q, lb_word_d;

    logic              sclk_s, mosi_s, ss_s;
    logic              sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic [DATA_W-1:0] rx_word;
    logic [DATA_W-1:0] load_word;
    logic              complete;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // A select is only honoured once ss_n has been seen high from the real pin,
    // so a select held low across reset cannot start a transfer.
    assign ss_fall   = ss_prev_q & ~ss_s & armed_q;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign rx_word   = {rx_sr_q, mosi_s};

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        prime_d     = {prime_q[SYNC_STAGES-2:0], 1'b1};
        sclk_prev_d = sclk_s;
        ss_prev_d   = ss_s;
        armed_d     = armed_q | (prime_q[SYNC_STAGES-1] & ss_s);
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        word_done_d = word_done_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        underrun_d  = underrun_q;
        lb_word_d   = lb_word_q;
        load_word   = TX_IDLE;
        complete    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d   = '0;
                word_done_d = 1'b0;
                if (ss_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (LOOPBACK_INC) begin
                    load_word = lb_word_q;
                end else if (tx_valid) begin
                    load_word = tx_data;
                end else begin
                    load_word  = TX_IDLE;
                    underrun_d = 1'b1;
                end
                tx_sr_d = load_word;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_sr_d = rx_word[DATA_W-2:0];
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d   = '0;
                        word_done_d = 1'b1;
                        complete    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
                if (sclk_fall) begin
                    if (word_done_q) begin
                        word_done_d = 1'b0;
                        state_d     = ST_LOAD;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ss_rise) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            word_done_d = 1'b0;
        end

        if (complete) begin
            lb_word_d = rx_word + DATA_W'(1);
            if (!rx_valid_q || rx_ready) begin
                rx_data_d  = rx_word;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        tx_ready_d = (state_d == ST_LOAD) && !LOOPBACK_INC;
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= '1;
            prime_q     <= '0;
            sclk_prev_q <= 1'b0;
            ss_prev_q   <= 1'b1;
            armed_q     <= 1'b0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            word_done_q <= 1'b0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            underrun_q  <= 1'b0;
            lb_word_q   <= '0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            prime_q     <= prime_d;
            sclk_prev_q <= sclk_prev_d;
            ss_prev_q   <= ss_prev_d;
            armed_q     <= armed_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            word_done_q <= word_done_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
            underrun_q  <= underrun_d;
            lb_word_q   <= lb_word_d;
        end
    end

    assign miso     = tx_sr_q[DATA_W-1] & ~ss_s;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench for spi_slave_stream: a bit-banged mode-0 master drives one
// normal instance and one loopback instance sharing the SPI input pins.
module tb_spi_slave_stream;

    localparam int unsigned HALF = 8;
    localparam int unsigned SYNC = 2;

    logic        clk = 1'b0;
    logic        rst, rst_lb;
    logic        sclk, mosi, ss_n;
    logic        miso, miso_lb;
    logic [15:0] rx_data, rx_data_lb;
    logic        rx_valid, rx_valid_lb;
    logic        rx_ready;
    logic        rx_ready_lb = 1'b1;
    logic [15:0] tx_data;
    logic [15:0] tx_data_lb = 16'h0000;
    logic        tx_valid;
    logic        tx_valid_lb = 1'b1;
    logic        tx_ready, tx_ready_lb;
    logic        busy, busy_lb, overrun, overrun_lb, underrun, underrun_lb;

    logic        lb_mode;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned rx_hs = 0, rx_hs_lb = 0, tx_hs = 0, tx_rdy_lb_cnt = 0;
    logic [15:0] rx_last = '0, rx_last_lb = '0;
    logic [15:0] r1, r2;
    int unsigned k;

    always #5 clk = ~clk;

    spi_slave_stream #(
        .DATA_W(16), .SYNC_STAGES(SYNC), .TX_IDLE(16'h5AC3), .LOOPBACK_INC(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overrun(overrun), .underrun(underrun)
    );

    spi_slave_stream #(
        .DATA_W(16), .SYNC_STAGES(SYNC), .TX_IDLE(16'h5AC3), .LOOPBACK_INC(1'b1)
    ) dut_lb (
        .clk(clk), .rst(rst_lb), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .miso(miso_lb),
        .rx_data(rx_data_lb), .rx_valid(rx_valid_lb), .rx_ready(rx_ready_lb),
        .tx_data(tx_data_lb), .tx_valid(tx_valid_lb), .tx_ready(tx_ready_lb),
        .busy(busy_lb), .overrun(overrun_lb), .underrun(underrun_lb)
    );

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            rx_hs++;
            rx_last = rx_data;
        end
        if (rx_valid_lb && rx_ready_lb) begin
            rx_hs_lb++;
            rx_last_lb = rx_data_lb;
        end
        if (tx_ready_lb) tx_rdy_lb_cnt++;
    end

    // Producer offers a single TX word and withdraws it once accepted.
    always @(negedge clk) begin
        if (tx_ready && tx_valid) begin
            tx_hs++;
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [15:0] w, input int unsigned nbits, output logic [15:0] r);
        r = '0;
        for (int unsigned i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            wait_clk(HALF);
            sclk = 1'b1;
            r = {r[14:0], (lb_mode ? miso_lb : miso)};
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        ss_n = 1'b1;
        wait_clk(12);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; rst_lb = 1'b1;
        sclk = 1'b0; mosi = 1'b0; ss_n = 1'b1;
        rx_ready = 1'b1; tx_valid = 1'b1; tx_data = 16'h1234; lb_mode = 1'b0;
        wait_clk(4);
        check_eq("rst_rx_data", rx_data, 16'h0000);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_tx_ready", tx_ready, 0);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overrun", overrun, 0);
        check_eq("rst_underrun", underrun, 0);
        rst = 1'b0;
        wait_clk(8);

        // RX word plus TX handshake, then a second word with no TX data
        frame_start();
        spi_bits(16'hA55A, 16, r1);
        check_eq("tx_word1", r1, 16'h1234);
        check_eq("rx_hs1", rx_hs, 1);
        check_eq("rx_data1", rx_last, 16'hA55A);
        check_eq("ovr_after1", overrun, 0);
        check_eq("udr_after1", underrun, 0);
        spi_bits(16'h0F0F, 16, r2);
        frame_end();
        check_eq("tx_idle_word", r2, 16'h5AC3);
        check_eq("udr_set", underrun, 1);
        check_eq("tx_hs_once", tx_hs, 1);
        check_eq("rx_hs2", rx_hs, 2);
        check_eq("rx_data2", rx_last, 16'h0F0F);
        check_eq("busy_idle", busy, 0);

        // Overrun
        rx_ready = 1'b0;
        frame_start();
        spi_bits(16'h0001, 16, r1);
        spi_bits(16'h0002, 16, r2);
        frame_end();
        check_eq("ovr_valid", rx_valid, 1);
        check_eq("ovr_data", rx_data, 16'h0001);
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_no_hs", rx_hs, 2);
        rx_ready = 1'b1;
        wait_clk(8);
        check_eq("ovr_hs_once", rx_hs, 3);
        check_eq("ovr_hs_data", rx_last, 16'h0001);
        check_eq("ovr_valid_clr", rx_valid, 0);

        // Abort after 7 bits
        frame_start();
        spi_bits(16'hFFFF, 7, r1);
        wait_clk(HALF);
        ss_n = 1'b1;
        k = 0;
        while (busy && k < SYNC + 2) begin
            @(negedge clk);
            k++;
        end
        check_eq("abort_busy", busy, 0);
        wait_clk(12);
        check_eq("abort_no_hs", rx_hs, 3);
        frame_start();
        spi_bits(16'hBEEF, 16, r1);
        frame_end();
        check_eq("abort_next_hs", rx_hs, 4);
        check_eq("abort_next_data", rx_last, 16'hBEEF);

        // Reset mid-frame after 9 bits, select still held low
        frame_start();
        spi_bits(16'hFFFF, 9, r1);
        rst = 1'b1;
        wait_clk(2);
        check_eq("mrst_rx_data", rx_data, 16'h0000);
        check_eq("mrst_rx_valid", rx_valid, 0);
        check_eq("mrst_tx_ready", tx_ready, 0);
        check_eq("mrst_miso", miso, 0);
        check_eq("mrst_busy", busy, 0);
        check_eq("mrst_overrun", overrun, 0);
        check_eq("mrst_underrun", underrun, 0);
        rst = 1'b0;
        wait_clk(20);
        check_eq("mrst_no_start", busy, 0);
        ss_n = 1'b1;
        wait_clk(8);
        frame_start();
        spi_bits(16'hC3C3, 16, r1);
        frame_end();
        check_eq("mrst_next_hs", rx_hs, 5);
        check_eq("mrst_next_data", rx_last, 16'hC3C3);

        // Loopback instance
        rst_lb = 1'b0;
        wait_clk(4);
        check_eq("lb_rst_busy", busy_lb, 0);
        lb_mode = 1'b1;
        frame_start();
        spi_bits(16'h00FF, 16, r1);
        spi_bits(16'h1000, 16, r2);
        frame_end();
        check_eq("lb_word1", r1, 16'h0000);
        check_eq("lb_word2", r2, 16'h0100);
        check_eq("lb_tx_ready", tx_rdy_lb_cnt, 0);
        check_eq("lb_rx_hs", rx_hs_lb, 2);
        check_eq("lb_rx_data", rx_last_lb, 16'h1000);
        check_eq("lb_underrun", underrun_lb, 0);
        check_eq("lb_overrun", overrun_lb, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
